// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin subtractor, LSB first, valid/ready in and out
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;

    // Single full-subtractor cell working on the operand LSBs
    assign a_bit    = a_sr[0];
    assign b_bit    = b_sr[0];
    assign d_bit    = a_bit ^ b_bit ^ br;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            DIFF   <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= Bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    // Result registers only move on the final bit
                    if (last_bit) begin
                        DIFF <= {d_bit, res_sr[WIDTH-1:1]};
                        Bout <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
